switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Input conditioner between the board's raw slide switches and the CPU's `switches[7:0]` input, which feeds the memory-mapped I/O read port. Each bit passes through a two-flop synchronizer and an independent debounce counter, so the CPU reads only stable, glitch-free levels. The block also produces per-bit edge pulses and a sticky change record with an acknowledge input for polling or future interrupt use.

## Interface
- `WIDTH`, 8, number of switch bits.
- `DEBOUNCE_CYCLES`, 50000, consecutive `clk` cycles a synchronized level must differ from the stable level before it is committed; legal range 1..2^`CNT_W`.
- `CNT_W`, 16, debounce counter width per bit.
- `clk`  in  1  system clock, the same clock as the CPU.
- `rst_n`  in  1  asynchronous, active-low reset.
- `switches_raw`  in  WIDTH  raw, asynchronous switch levels.
- `ack`  in  1  clears all sticky change bits.
- `switches`  out  WIDTH  debounced stable levels, connected to the CPU `switches` port.
- `rise`  out  WIDTH  one-cycle pulse per bit on a committed 0->1 change.
- `fall`  out  WIDTH  one-cycle pulse per bit on a committed 1->0 change.
- `pending_bits`  out  WIDTH  sticky per-bit "changed since last ack".
- `pending`  out  1  OR-reduction of `pending_bits`.

## Operation
- **Synchronizer:** per bit, `sync1 <= switches_raw[i]` and `sync2 <= sync1`. Both reset to 0.
- **Per-bit FSM, STABLE state:** counter is 0.
  - `sync2 == switches[i]`: stay in STABLE.
  - `sync2 != switches[i]`: go to COUNTING with counter = 1.
  - If `DEBOUNCE_CYCLES == 1`, commit immediately instead of entering COUNTING.
- **Per-bit FSM, COUNTING state:**
  - `sync2 == switches[i]` (bounce): counter = 0, return to STABLE. Any bounce fully restarts the count.
  - `sync2 != switches[i]` and counter < `DEBOUNCE_CYCLES`-1: increment the counter.
  - `sync2 != switches[i]` and counter == `DEBOUNCE_CYCLES`-1: commit.
- **Commit:**
  - `switches[i] <= sync2`, counter = 0, state = STABLE.
  - `rise[i]` or `fall[i]` is set for exactly the next cycle.
  - `pending_bits[i]` is set.
- **Edge pulses:** `rise` and `fall` are registered and cleared on every edge without a commit. Consecutive commits on the same bit are impossible within fewer than `DEBOUNCE_CYCLES` cycles.
- **Sticky bits:**
  - `ack` high at an edge clears every `pending_bits` bit.
  - A commit on the same edge as `ack` sets that bit; set wins.
- **Bit independence:** bits do not interact. Simultaneous commits on several bits pulse and set pending on all of them in the same cycle.
- **Counter width:** counters never wrap. The terminal compare stops them at `DEBOUNCE_CYCLES`-1.

## Timing
- **Reset:** asynchronous assertion clears all of the following to 0:
  - `sync1`, `sync2`, `switches`, `rise`, `fall`, `pending_bits`, `pending`
  - all counters
  - all FSMs, which go to STABLE
- **Reset mid-count:** the count is discarded. After release, a raw level held at 1 re-debounces from scratch and produces a `rise` pulse.
- **Latency:** let `switches_raw[i]` first be sampled at edge t and stay constant. Then:
  - `switches[i]` changes after edge t+`DEBOUNCE_CYCLES`+1.
  - `rise[i]`/`fall[i]` are high for the cycle following that edge.
  - `pending_bits[i]` sets on that same edge.
- **Pulse width:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never reaches `switches`.
- **Output registers:** all outputs are registered. `pending` may be combinational from `pending_bits`. There are no combinational paths from inputs to outputs.
- **Throughput:** one commit per bit per `DEBOUNCE_CYCLES` cycles at most.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `WIDTH`=8.
- **Clean rise:** reset, then `switches_raw`=8'h01 from edge 0 -> `switches` is 8'h01 after edge 5, `rise`=8'h01 for one cycle, `pending`=1 and `pending_bits`=8'h01 thereafter.
- **Bounce rejection:** `switches_raw[0]` toggles 1,1,1,0,1,1,1,1 on successive edges -> no commit until 4 consecutive mismatching `sync2` samples; `switches[0]` rises 4 edges after the last bounce reaches `sync2`. A 3-cycle pulse on bit 3 never changes `switches`.
- **Multi-bit and fall:** `switches` stable at 8'hFF, then `switches_raw`=8'h0F -> `switches`=8'h0F after 5 edges, `fall`=8'hF0 for one cycle, `rise`=0.
- **Ack vs. commit:** `pending_bits`=8'h01, then `ack` on the same edge as a bit-2 commit -> `pending_bits`=8'h04. `ack` with no commit -> `pending_bits`=0, `pending`=0.
- **Async reset mid-count:** assert `rst_n`=0 between clock edges while bit 5 has counter=2 -> all outputs go to 0 immediately. Release with raw bit 5 still at 1 -> `rise[5]` pulses 5 edges after the first post-reset sample.
- **Boundary:** `DEBOUNCE_CYCLES`=1 -> a raw change sampled at edge t appears on `switches` after edge t+2 with a single-cycle edge pulse.

Source files
------------

// File: rtl/switch_debouncer.sv
// Switch input conditioner: two-flop synchronizer plus per-bit debounce FSM, with
// registered edge pulses and a sticky change record cleared by ack.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switches_raw,
  input  logic             ack,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pending_bits,
  output logic             pending
);

  typedef enum logic {StStable, StCounting} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] commit;
  state_e           st_q  [WIDTH];
  state_e           st_d  [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    stable_d = stable_q;
    commit   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StStable: begin
          if (sync2_q[i] != stable_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              commit[i] = 1'b1;
            end else begin
              st_d[i]  = StCounting;
              cnt_d[i] = CntOne;
            end
          end
        end
        StCounting: begin
          if (sync2_q[i] == stable_q[i]) begin
            // Any bounce restarts the full debounce window.
            st_d[i]  = StStable;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            commit[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          st_d[i]  = StStable;
          cnt_d[i] = '0;
        end
      endcase
      if (commit[i]) begin
        stable_d[i] = sync2_q[i];
        st_d[i]     = StStable;
        cnt_d[i]    = '0;
      end
    end
    rise_d = commit & sync2_q;
    fall_d = commit & ~sync2_q;
    // Set wins over a simultaneous ack.
    pend_d = (ack ? '0 : pend_q) | commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        st_q[i]  <= StStable;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= switches_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switches     = stable_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign pending_bits = pend_q;
  assign pending      = |pend_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: vector table, hand-written corner sequences, and a
// random run against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw = '0, raw1 = '0;
  logic       ack = 1'b0;
  logic [7:0] sw, ri, fa, pb, sw1, ri1, fa1, pb1;
  logic       pe, pe1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .switches_raw(raw), .ack(ack), .switches(sw),
    .rise(ri), .fall(fa), .pending_bits(pb), .pending(pe)
  );

  switch_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .switches_raw(raw1), .ack(1'b0), .switches(sw1),
    .rise(ri1), .fall(fa1), .pending_bits(pb1), .pending(pe1)
  );

  // Reference model: a level commits when the last D synchronized samples (raw delayed
  // by two edges) all differ from the committed level. hist[0] is the raw level of the
  // previous edge.
  logic [7:0] hist [D+1];
  logic [7:0] m_sw, m_ri, m_fa, m_pb;

  function automatic logic [7:0] commits(input logic [7:0] h [D+1], input logic [7:0] s);
    logic [7:0] c;
    c = 8'hFF;
    for (int k = 1; k <= D; k++) c &= h[k] ^ s;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D; k++) hist[k] <= '0;
      m_sw <= '0; m_ri <= '0; m_fa <= '0; m_pb <= '0;
    end else begin
      hist[0] <= raw;
      for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
      m_sw <= m_sw ^ commits(hist, m_sw);
      m_ri <= commits(hist, m_sw) & ~m_sw;
      m_fa <= commits(hist, m_sw) & m_sw;
      m_pb <= (ack ? 8'h00 : m_pb) | commits(hist, m_sw);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    raw = '0; raw1 = '0; ack = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] raw;
    logic       ack;
    logic [7:0] sw, ri, fa, pb;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input int n, input logic [7:0] r, input logic a,
                              input logic [7:0] s, input logic [7:0] ris,
                              input logic [7:0] fal, input logic [7:0] p);
    vec_t v;
    v.raw = r; v.ack = a; v.sw = s; v.ri = ris; v.fa = fal; v.pb = p;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    // Clean rise, ack vs. commit, multi-bit rise and fall.
    add(5, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h01, 0, 8'h01, 8'h01, 8'h00, 8'h01);
    add(1, 8'h01, 0, 8'h01, 8'h00, 8'h00, 8'h01);
    add(5, 8'h05, 0, 8'h01, 8'h00, 8'h00, 8'h01);
    add(1, 8'h05, 1, 8'h05, 8'h04, 8'h00, 8'h04);
    add(1, 8'h05, 1, 8'h05, 8'h00, 8'h00, 8'h00);
    add(1, 8'h05, 0, 8'h05, 8'h00, 8'h00, 8'h00);
    add(5, 8'hFF, 0, 8'h05, 8'h00, 8'h00, 8'h00);
    add(1, 8'hFF, 0, 8'hFF, 8'hFA, 8'h00, 8'hFA);
    add(1, 8'hFF, 0, 8'hFF, 8'h00, 8'h00, 8'hFA);
    add(5, 8'h0F, 0, 8'hFF, 8'h00, 8'h00, 8'hFA);
    add(1, 8'h0F, 0, 8'h0F, 8'h00, 8'hF0, 8'hFA);
    add(1, 8'h0F, 0, 8'h0F, 8'h00, 8'h00, 8'hFA);

    do_reset();
    chk("reset_switches", sw, 8'h00);
    chk("reset_pending", {7'd0, pe}, 8'h00);
    foreach (tbl[i]) begin
      raw = tbl[i].raw; ack = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_switches", i), sw, tbl[i].sw);
      chk($sformatf("tbl%0d_rise", i), ri, tbl[i].ri);
      chk($sformatf("tbl%0d_fall", i), fa, tbl[i].fa);
      chk($sformatf("tbl%0d_pending_bits", i), pb, tbl[i].pb);
      chk($sformatf("tbl%0d_pending", i), {7'd0, pe}, {7'd0, |tbl[i].pb});
    end
    ack = 1'b0;

    // Bounce on bit 0, too-short pulse on bit 3.
    do_reset();
    begin
      logic [7:0] b0, b3;
      b0 = 8'b1111_0111;
      b3 = 8'b0000_0111;
      for (int k = 0; k < 12; k++) begin
        raw = '0;
        raw[0] = (k < 8) ? b0[k] : 1'b1;
        raw[3] = (k < 8) ? b3[k] : 1'b0;
        step();
        chk($sformatf("bounce_e%0d_bit0", k), {7'd0, sw[0]}, {7'd0, k >= 9});
        chk($sformatf("bounce_e%0d_bit3", k), {7'd0, sw[3]}, 8'h00);
      end
    end

    // Async reset while bit 5 is mid-count.
    raw = 8'h21;
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_switches", sw, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_switches", sw, 8'h00);
    chk("async_rst_pending_bits", pb, 8'h00);
    chk("async_rst_pending", {7'd0, pe}, 8'h00);
    #1 rst_n = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      step();
      chk($sformatf("rerise_e%0d_rise", j), ri, (j == 5) ? 8'h21 : 8'h00);
      chk($sformatf("rerise_e%0d_switches", j), sw, (j == 5) ? 8'h21 : 8'h00);
    end

    // DEBOUNCE_CYCLES = 1 boundary on the second instance.
    raw1 = 8'h01;
    for (int j = 0; j <= 3; j++) begin
      step();
      chk($sformatf("d1_e%0d_switches", j), sw1, (j >= 2) ? 8'h01 : 8'h00);
      chk($sformatf("d1_e%0d_rise", j), ri1, (j == 2) ? 8'h01 : 8'h00);
    end

    // Random run against the window model, with occasional async resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(3) == 0) raw[b] = ~raw[b];
      ack = ($urandom_range(7) == 0);
      step();
      chk("rnd_switches", sw, m_sw);
      chk("rnd_rise", ri, m_ri);
      chk("rnd_fall", fa, m_fa);
      chk("rnd_pending_bits", pb, m_pb);
      chk("rnd_pending", {7'd0, pe}, {7'd0, |m_pb});
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
